div_clk_monitor: RTL
====================

DIV_CLK_MONITOR -- requirements
Module: div_clk_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the period and high-time counters.
REQ-002 SHALL have parameter TIMEOUT, default 16'hFFFF, the clk_i cycles allowed without a clk_div edge before error.
REQ-003 SHALL have port clk_i, input, 1 bit: the single reference clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port clk_div, input, 1 bit: divided clock from the odd-ratio divider stage, treated as asynchronous data.
REQ-006 SHALL have port en, input, 1 bit: measurement enable; low forces IDLE.
REQ-007 SHALL have port period_o, output, CNT_W bits: clk_i cycles between the last two clk_div rising edges.
REQ-008 SHALL have port high_o, output, CNT_W bits: clk_i cycles clk_div was sampled high in that period.
REQ-009 SHALL have port meas_valid, output, 1 bit: one-cycle pulse when period_o/high_o update.
REQ-010 SHALL have port duty_ok, output, 1 bit: |2*high_o - period_o| <= 1, valid with period_o.
REQ-011 SHALL have port timeout_err, output, 1 bit: sticky flag, no clk_div edge within TIMEOUT cycles.

Function
REQ-012 SHALL synchronise clk_div through two flops, then register once more for edge detection; rising edge = sync high and delayed low; detection latency 3 clk_i cycles.
REQ-013 SHALL implement states IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
REQ-014 SHALL transition IDLE->WAIT_RISE when en=1; any state->IDLE when en=0, within the same cycle.
REQ-015 SHALL transition WAIT_RISE->MEAS_HIGH on rising edge, clearing cnt_per to 1 and cnt_high to 1.
REQ-016 SHALL in MEAS_HIGH/MEAS_LOW increment cnt_per every cycle, and increment cnt_high every cycle the synchronised clk_div is 1.
REQ-017 SHALL transition MEAS_HIGH->MEAS_LOW on falling edge of the synchronised clk_div.
REQ-018 SHALL in MEAS_LOW on rising edge: latch period_o=cnt_per, high_o=cnt_high, duty_ok, pulse meas_valid for one cycle, restart counters at 1, and enter MEAS_HIGH; measurement is continuous.
REQ-019 SHALL compute duty_ok using CNT_W+2-bit signed arithmetic with no truncation.
REQ-020 SHALL saturate cnt_per at TIMEOUT; on reaching it in any non-IDLE state set timeout_err=1 and return to WAIT_RISE.
REQ-021 SHALL keep timeout_err set until reset or en deasserted.
REQ-022 SHALL hold period_o, high_o, duty_ok at their last values when IDLE, WAIT_RISE, or during timeout.
REQ-023 SHALL on a rising edge in MEAS_HIGH (missed falling edge, high >= period) treat it as a period end, per REQ-018.
REQ-024 SHALL, when en falls in the same cycle as a completing rising edge, give priority to en: no meas_valid, no update.

Reset
REQ-025 SHALL on rst_n=0 asynchronously clear synchroniser flops, counters, period_o, high_o, meas_valid, duty_ok, and timeout_err to 0, with state IDLE.
REQ-026 SHALL, after rst_n deasserts mid-operation, require a fresh WAIT_RISE before any meas_valid.

Structure
REQ-027 SHALL place the state enum, CNT_W default, and TIMEOUT default in shared package div_mon_pkg.
REQ-028 SHALL implement the two-flop synchroniser as sub-module sync_2ff, with ports clk_i, rst_n, d, q.
REQ-029 SHALL keep counters, FSM, and output registers in div_clk_monitor; no other sub-modules.

Verification
REQ-030 SHALL cover: clk_i 2 ns period, divide-by-5 50% clk_div, en=1 -> from the second period on, meas_valid every 5 cycles, period_o=5, high_o in {2,3}, duty_ok=1.
REQ-031 SHALL cover: clk_div period 8 with high 2 -> period_o=8, high_o=2, duty_ok=0.
REQ-032 SHALL cover: clk_div held at 0 with TIMEOUT=20 -> timeout_err=1 at 20 cycles after the last edge; outputs hold their prior values.
REQ-033 SHALL cover: en dropped mid-period, then re-raised -> no meas_valid until one full period after the first rising edge seen post-enable; timeout_err cleared.
REQ-034 SHALL cover: rst_n pulsed low for 3 cycles mid-measurement -> all outputs 0 immediately; divide-by-5 measurement resumes per REQ-030.
REQ-035 SHALL cover: en falling on the completing-edge cycle -> no meas_valid pulse; period_o unchanged.

Source files
------------

// File: rtl/div_mon_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the divided-clock monitor.
package div_mon_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } mon_state_e;

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// Two-flop synchroniser bringing an asynchronous level into the clk_i domain.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= 2'b00;
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/div_clk_monitor.sv
`timescale 1ns/1ps
// Measures period and high time of the divided clock in clk_i cycles, flags
// duty balance within one cycle, and raises a sticky flag when edges stop.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             en,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             meas_valid,
  output logic             duty_ok,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0]        TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]        CNT_ONE     = CNT_W'(1);
  localparam logic signed [CNT_W+1:0] DIFF_ONE    = (CNT_W+2)'(1);

  // Two extra bits keep 2*high - period exact for any counter value.
  function automatic logic duty_balanced(input logic [CNT_W-1:0] per,
                                         input logic [CNT_W-1:0] hi);
    logic signed [CNT_W+1:0] diff;
    diff = $signed({1'b0, hi, 1'b0}) - $signed({2'b00, per});
    return (diff >= -DIFF_ONE) && (diff <= DIFF_ONE);
  endfunction

  mon_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_per_reg, cnt_per_next;
  logic [CNT_W-1:0] cnt_high_reg, cnt_high_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic             duty_ok_reg, duty_ok_next;
  logic             meas_valid_reg, meas_valid_next;
  logic             timeout_err_reg, timeout_err_next;
  logic             div_dly_reg;
  logic             div_sync, div_rise, div_fall;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .d     (clk_div),
    .q     (div_sync)
  );

  assign div_rise = div_sync & ~div_dly_reg;
  assign div_fall = ~div_sync & div_dly_reg;

  always_comb begin
    state_next       = state_reg;
    cnt_per_next     = cnt_per_reg;
    cnt_high_next    = cnt_high_reg;
    period_next      = period_reg;
    high_next        = high_reg;
    duty_ok_next     = duty_ok_reg;
    meas_valid_next  = 1'b0;
    timeout_err_next = timeout_err_reg;

    if (!en) begin
      state_next       = IDLE;
      cnt_per_next     = '0;
      cnt_high_next    = '0;
      timeout_err_next = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          // The wait for a first edge is itself timed from here.
          state_next    = WAIT_RISE;
          cnt_per_next  = CNT_ONE;
          cnt_high_next = '0;
        end
        WAIT_RISE: begin
          if (div_rise) begin
            state_next    = MEAS_HIGH;
            cnt_per_next  = CNT_ONE;
            cnt_high_next = CNT_ONE;
          end else if (cnt_per_reg >= TIMEOUT_CNT) begin
            timeout_err_next = 1'b1;
          end else begin
            cnt_per_next = cnt_per_reg + CNT_ONE;
          end
        end
        MEAS_HIGH, MEAS_LOW: begin
          if (div_rise) begin
            // A rise while still high means the falling edge was missed; close the period anyway.
            period_next     = cnt_per_reg;
            high_next       = cnt_high_reg;
            duty_ok_next    = duty_balanced(cnt_per_reg, cnt_high_reg);
            meas_valid_next = 1'b1;
            cnt_per_next    = CNT_ONE;
            cnt_high_next   = CNT_ONE;
            state_next      = MEAS_HIGH;
          end else if (cnt_per_reg >= TIMEOUT_CNT) begin
            timeout_err_next = 1'b1;
            state_next       = WAIT_RISE;
          end else begin
            cnt_per_next  = cnt_per_reg + CNT_ONE;
            cnt_high_next = cnt_high_reg + CNT_W'(div_sync);
            if (state_reg == MEAS_HIGH && div_fall) begin
              state_next = MEAS_LOW;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_per_reg     <= '0;
      cnt_high_reg    <= '0;
      period_reg      <= '0;
      high_reg        <= '0;
      duty_ok_reg     <= 1'b0;
      meas_valid_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      div_dly_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_per_reg     <= cnt_per_next;
      cnt_high_reg    <= cnt_high_next;
      period_reg      <= period_next;
      high_reg        <= high_next;
      duty_ok_reg     <= duty_ok_next;
      meas_valid_reg  <= meas_valid_next;
      timeout_err_reg <= timeout_err_next;
      div_dly_reg     <= div_sync;
    end
  end

  assign period_o    = period_reg;
  assign high_o      = high_reg;
  assign duty_ok     = duty_ok_reg;
  assign meas_valid  = meas_valid_reg;
  assign timeout_err = timeout_err_reg;

endmodule
